count_dir_decoder: RTL and testbench
====================================

COUNT_DIR_DECODER -- requirements
Module: count_dir_decoder

Interface
REQ-001 The block SHALL have parameter LOCK_THRESH, default 4, giving the run length (1..255) at which Locked asserts.
REQ-002 The block SHALL have one clock, and reset SHALL be synchronous and active-high.
REQ-003 Port Clk  input  1  clock; all state updates on rising edge.
REQ-004 Port reset  input  1  synchronous active-high reset.
REQ-005 Port CountIn  input  4  sampled value of a 4-bit wrapping up/down count.
REQ-006 Port Sample  input  1  CountIn valid this cycle; CountIn ignored when low.
REQ-007 Port Dir  output  1  last decoded direction, 1=up, 0=down.
REQ-008 Port Step  output  1  one-cycle pulse: a legal +1/-1 step was decoded.
REQ-009 Port Wrap  output  1  one-cycle pulse: the decoded step crossed 15->0 (up) or 0->15 (down).
REQ-010 Port Err  output  1  one-cycle pulse: a non-adjacent jump was seen.
REQ-011 Port RunLen  output  8  consecutive same-direction steps, saturating.
REQ-012 Port Locked  output  1  level; high when State is UP or DOWN and RunLen >= LOCK_THRESH.
REQ-013 Port State  output  2  FSM state encoding: UNSYNC=0, SYNC=1, UP=2, DOWN=3.
REQ-014 Port WrapCnt  output  8  wrap event count (see Configuration).

Function
REQ-015 All outputs SHALL be registered; the response to a Sample in cycle N SHALL appear after the Clk edge that ends cycle N (1-cycle latency).
REQ-016 With Sample low, the block SHALL hold state, prev, Dir, RunLen and WrapCnt, and SHALL drive Step, Wrap and Err low.
REQ-017 In UNSYNC, Sample SHALL load prev<=CountIn and move the FSM to SYNC with no pulse.
REQ-018 In SYNC/UP/DOWN, the block SHALL compute delta=(CountIn-prev) mod 16 and update prev<=CountIn on every Sample.
REQ-019 delta=0 SHALL be a hold: no pulse, no state change, and RunLen unchanged.
REQ-020 delta=1 SHALL pulse Step, set Dir=1 and go to UP; delta=15 SHALL pulse Step, set Dir=0 and go to DOWN.
REQ-021 RunLen SHALL increment on a step in the same direction as the current UP/DOWN state, saturating at 255; the first step from SYNC or a reversal SHALL set RunLen=1.
REQ-022 Any other delta (2..14) SHALL pulse Err, go to SYNC and clear RunLen to 0; Dir SHALL hold, and prev SHALL take CountIn (resync).
REQ-023 Wrap SHALL pulse together with Step for prev=15 to CountIn=0 (up) or prev=0 to CountIn=15 (down).
REQ-024 At most one of Step and Err SHALL be high in any cycle.

Reset
REQ-025 When reset is high at a Clk edge, the block SHALL set State=UNSYNC and prev=0, and drive Dir, Step, Wrap, Err, RunLen, Locked and WrapCnt to 0; reset SHALL override Sample.
REQ-026 Reset mid-run SHALL discard history; the first Sample after reset SHALL only resync and SHALL produce no pulse.

Configuration
REQ-027 With macro UDC_WRAPCNT_EN defined, WrapCnt SHALL increment by 1 (mod 256) on each Wrap pulse.
REQ-028 Without UDC_WRAPCNT_EN, WrapCnt SHALL be tied to 0, no counter logic SHALL be inferred, and the port list SHALL stay unchanged.

Structure
REQ-029 Shared package udc_pkg SHALL hold the state encodings (UNSYNC, SYNC, UP, DOWN), DELTA_UP=4'd1, DELTA_DN=4'd15 and RUN_MAX=8'd255.
REQ-030 Combinational sub-module udc_step_classifier (prev, cur -> is_hold, is_up, is_dn, is_err, is_wrap) SHALL be instantiated once.

Verification
REQ-031 Bench case: reset, then Samples 3,4,5,6,7 -> 4 Step pulses; Dir=1; State=UP; RunLen=4; Locked=1 after the 7 sample.
REQ-032 Bench case: Samples 14,15,0,1 -> Wrap pulses only on the 15->0 step; with UDC_WRAPCNT_EN, WrapCnt=1; without it, WrapCnt=0.
REQ-033 Bench case: Samples 1,0,15,14 -> Wrap on the 0->15 step; Dir=0; State=DOWN; RunLen=3.
REQ-034 Bench case: up-run of 5, then CountIn jumps 9->12 -> Err pulse; State=SYNC; RunLen=0; Locked=0; Dir stays 1; next sample 13 -> Step, State=UP, RunLen=1.
REQ-035 Bench case: up-run 5,6,7, then 6 -> reversal: Dir=0, RunLen=1, State=DOWN; then repeated 6 with Sample high -> no pulse, RunLen holds.
REQ-036 Bench case: reset asserted together with Sample mid-run -> all outputs 0, State=UNSYNC; next Sample produces no pulse.

Source files
------------

// File: rtl/udc_pkg.sv
// ============================================================================
// udc_pkg : shared encodings and constants for count_dir_decoder
// Revision: 1.0
// ============================================================================
`default_nettype none

package udc_pkg;

  typedef enum logic [1:0] {
    UNSYNC = 2'd0,
    SYNC   = 2'd1,
    UP     = 2'd2,
    DOWN   = 2'd3
  } udc_state_e;

  localparam logic [3:0] DELTA_UP = 4'd1;
  localparam logic [3:0] DELTA_DN = 4'd15;
  localparam logic [7:0] RUN_MAX  = 8'd255;

endpackage : udc_pkg

`default_nettype wire

// File: rtl/udc_step_classifier.sv
// ============================================================================
// udc_step_classifier : classifies a 4-bit count transition prev -> cur
// Revision: 1.0
// ============================================================================
`default_nettype none

module udc_step_classifier
  import udc_pkg::*;
(
  input  logic [3:0] prev_i,
  input  logic [3:0] cur_i,
  output logic       is_hold_o,
  output logic       is_up_o,
  output logic       is_dn_o,
  output logic       is_err_o,
  output logic       is_wrap_o
);

  logic [3:0] delta;

  // Modulo-16 difference falls out of the 4-bit subtraction.
  assign delta     = cur_i - prev_i;
  assign is_hold_o = (delta == 4'd0);
  assign is_up_o   = (delta == DELTA_UP);
  assign is_dn_o   = (delta == DELTA_DN);
  assign is_err_o  = !(is_hold_o || is_up_o || is_dn_o);
  assign is_wrap_o = (is_up_o && (prev_i == 4'd15)) || (is_dn_o && (prev_i == 4'd0));

endmodule : udc_step_classifier

`default_nettype wire

// File: rtl/count_dir_decoder.sv
// ============================================================================
// count_dir_decoder : direction/step decoder for a sampled 4-bit up/down count
// Optional wrap counter enabled by macro UDC_WRAPCNT_EN.  Revision: 1.0
// ============================================================================
`default_nettype none

module count_dir_decoder
  import udc_pkg::*;
#(
  parameter int LOCK_THRESH = 4
) (
  input  logic       Clk,
  input  logic       reset,
  input  logic [3:0] CountIn,
  input  logic       Sample,
  output logic       Dir,
  output logic       Step,
  output logic       Wrap,
  output logic       Err,
  output logic [7:0] RunLen,
  output logic       Locked,
  output logic [1:0] State,
  output logic [7:0] WrapCnt
);

  localparam logic [7:0] C_LOCK_THRESH = 8'(LOCK_THRESH);

  udc_state_e state_q, state_d;
  logic [3:0] prev_q, prev_d;
  logic       dir_q, dir_d;
  logic       step_q, step_d;
  logic       wrap_q, wrap_d;
  logic       err_q, err_d;
  logic [7:0] runlen_q, runlen_d;
  logic       lock_q, lock_d;

  logic is_hold, is_up, is_dn, is_err, is_wrap;

  udc_step_classifier u_classifier (
    .prev_i    (prev_q),
    .cur_i     (CountIn),
    .is_hold_o (is_hold),
    .is_up_o   (is_up),
    .is_dn_o   (is_dn),
    .is_err_o  (is_err),
    .is_wrap_o (is_wrap)
  );

  always_comb begin
    state_d  = state_q;
    prev_d   = prev_q;
    dir_d    = dir_q;
    step_d   = 1'b0;
    wrap_d   = 1'b0;
    err_d    = 1'b0;
    runlen_d = runlen_q;
    if (Sample) begin
      prev_d = CountIn;
      if (state_q == UNSYNC) begin
        state_d = SYNC;
      end else if (!is_hold) begin
        if (is_up) begin
          step_d   = 1'b1;
          wrap_d   = is_wrap;
          dir_d    = 1'b1;
          state_d  = UP;
          runlen_d = (state_q != UP) ? 8'd1 :
                     (runlen_q == RUN_MAX) ? RUN_MAX : runlen_q + 8'd1;
        end else if (is_dn) begin
          step_d   = 1'b1;
          wrap_d   = is_wrap;
          dir_d    = 1'b0;
          state_d  = DOWN;
          runlen_d = (state_q != DOWN) ? 8'd1 :
                     (runlen_q == RUN_MAX) ? RUN_MAX : runlen_q + 8'd1;
        end else if (is_err) begin
          err_d    = 1'b1;
          state_d  = SYNC;
          runlen_d = 8'd0;
        end
      end
    end
    // Lock is derived from the next state so it stays aligned with RunLen.
    lock_d = ((state_d == UP) || (state_d == DOWN)) && (runlen_d >= C_LOCK_THRESH);
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      state_q  <= UNSYNC;
      prev_q   <= 4'd0;
      dir_q    <= 1'b0;
      step_q   <= 1'b0;
      wrap_q   <= 1'b0;
      err_q    <= 1'b0;
      runlen_q <= 8'd0;
      lock_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      prev_q   <= prev_d;
      dir_q    <= dir_d;
      step_q   <= step_d;
      wrap_q   <= wrap_d;
      err_q    <= err_d;
      runlen_q <= runlen_d;
      lock_q   <= lock_d;
    end
  end

`ifdef UDC_WRAPCNT_EN
  logic [7:0] wrapcnt_q;

  always_ff @(posedge Clk) begin
    if (reset) begin
      wrapcnt_q <= 8'd0;
    end else if (wrap_d) begin
      wrapcnt_q <= wrapcnt_q + 8'd1;
    end
  end

  assign WrapCnt = wrapcnt_q;
`else
  assign WrapCnt = 8'd0;
`endif

  assign Dir    = dir_q;
  assign Step   = step_q;
  assign Wrap   = wrap_q;
  assign Err    = err_q;
  assign RunLen = runlen_q;
  assign Locked = lock_q;
  assign State  = state_q;

endmodule : count_dir_decoder

`default_nettype wire

// File: tb/tb_count_dir_decoder.sv
// ============================================================================
// tb_count_dir_decoder : table-driven checks for count_dir_decoder
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_count_dir_decoder;

  logic       Clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] CountIn = 4'd0;
  logic       Sample = 1'b0;
  logic       Dir, Step, Wrap, Err, Locked;
  logic [7:0] RunLen, WrapCnt;
  logic [1:0] State;

  int n_checks = 0;
  int n_pass   = 0;

  count_dir_decoder #(.LOCK_THRESH(4)) dut (
    .Clk     (Clk),
    .reset   (reset),
    .CountIn (CountIn),
    .Sample  (Sample),
    .Dir     (Dir),
    .Step    (Step),
    .Wrap    (Wrap),
    .Err     (Err),
    .RunLen  (RunLen),
    .Locked  (Locked),
    .State   (State),
    .WrapCnt (WrapCnt)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic       rst;
    logic       smp;
    logic [3:0] cnt;
    logic       dir;
    logic       step;
    logic       wrap;
    logic       err;
    logic [7:0] rl;
    logic       lock;
    logic [1:0] st;
    logic [7:0] wc;  // expected WrapCnt when the wrap counter is built in
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(input logic rst, input logic smp, input int cnt,
                             input logic dir, input logic step, input logic wrap,
                             input logic err, input int rl, input logic lock,
                             input int st, input int wc);
    vec_t r;
    r.rst = rst; r.smp = smp; r.cnt = 4'(cnt);
    r.dir = dir; r.step = step; r.wrap = wrap; r.err = err;
    r.rl = 8'(rl); r.lock = lock; r.st = 2'(st); r.wc = 8'(wc);
    return r;
  endfunction

  function automatic logic [7:0] exp_wc(input logic [7:0] wc);
`ifdef UDC_WRAPCNT_EN
    return wc;
`else
    return 8'd0 & wc;
`endif
  endfunction

  task automatic check(input string name, input logic [22:0] got, input logic [22:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got dir,step,wrap,err,rl,lock,st,wc=%h required %h", name, got, exp);
  endtask

  task automatic apply(input vec_t x, input string name);
    reset   = x.rst;
    Sample  = x.smp;
    CountIn = x.cnt;
    @(posedge Clk);
    #1;
    check(name, {Dir, Step, Wrap, Err, RunLen, Locked, State, WrapCnt},
          {x.dir, x.step, x.wrap, x.err, x.rl, x.lock, x.st, exp_wc(x.wc)});
  endtask

  initial begin
    //               rst smp cnt dir st wr er rl lk st wc
    // up-run 3..7 then idle
    vecs.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(v(0, 1, 3, 0, 0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(v(0, 1, 4, 1, 1, 0, 0, 1, 0, 2, 0));
    vecs.push_back(v(0, 1, 5, 1, 1, 0, 0, 2, 0, 2, 0));
    vecs.push_back(v(0, 1, 6, 1, 1, 0, 0, 3, 0, 2, 0));
    vecs.push_back(v(0, 1, 7, 1, 1, 0, 0, 4, 1, 2, 0));
    vecs.push_back(v(0, 0, 2, 1, 0, 0, 0, 4, 1, 2, 0));
    // up wrap 14,15,0,1
    vecs.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(v(0, 1, 14, 0, 0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(v(0, 1, 15, 1, 1, 0, 0, 1, 0, 2, 0));
    vecs.push_back(v(0, 1, 0, 1, 1, 1, 0, 2, 0, 2, 1));
    vecs.push_back(v(0, 1, 1, 1, 1, 0, 0, 3, 0, 2, 1));
    // down wrap 1,0,15,14
    vecs.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(v(0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(v(0, 1, 0, 0, 1, 0, 0, 1, 0, 3, 0));
    vecs.push_back(v(0, 1, 15, 0, 1, 1, 0, 2, 0, 3, 1));
    vecs.push_back(v(0, 1, 14, 0, 1, 0, 0, 3, 0, 3, 1));
    // up-run 5..9, jump to 12, then 13
    vecs.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(v(0, 1, 5, 0, 0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(v(0, 1, 6, 1, 1, 0, 0, 1, 0, 2, 0));
    vecs.push_back(v(0, 1, 7, 1, 1, 0, 0, 2, 0, 2, 0));
    vecs.push_back(v(0, 1, 8, 1, 1, 0, 0, 3, 0, 2, 0));
    vecs.push_back(v(0, 1, 9, 1, 1, 0, 0, 4, 1, 2, 0));
    vecs.push_back(v(0, 1, 12, 1, 0, 0, 1, 0, 0, 1, 0));
    vecs.push_back(v(0, 1, 13, 1, 1, 0, 0, 1, 0, 2, 0));
    // reversal 5,6,7,6 then repeated 6
    vecs.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(v(0, 1, 5, 0, 0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(v(0, 1, 6, 1, 1, 0, 0, 1, 0, 2, 0));
    vecs.push_back(v(0, 1, 7, 1, 1, 0, 0, 2, 0, 2, 0));
    vecs.push_back(v(0, 1, 6, 0, 1, 0, 0, 1, 0, 3, 0));
    vecs.push_back(v(0, 1, 6, 0, 0, 0, 0, 1, 0, 3, 0));
    vecs.push_back(v(0, 1, 6, 0, 0, 0, 0, 1, 0, 3, 0));
    // reset with Sample mid-run, then resync without pulse
    vecs.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(v(0, 1, 15, 0, 0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(v(0, 1, 0, 1, 1, 1, 0, 1, 0, 2, 1));
    vecs.push_back(v(0, 1, 1, 1, 1, 0, 0, 2, 0, 2, 1));
    vecs.push_back(v(1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(v(0, 1, 7, 0, 0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(v(0, 1, 8, 1, 1, 0, 0, 1, 0, 2, 0));

    @(posedge Clk);
    #1;
    foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

    // RunLen saturation over a long up-run from 0: 300 steps, wrap on every 16th
    apply(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "sat_reset");
    apply(v(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0), "sat_sync");
    for (int i = 1; i <= 299; i++) begin
      reset = 1'b0; Sample = 1'b1; CountIn = 4'(i);
      @(posedge Clk);
      #1;
    end
    apply(v(0, 1, 300 % 16, 1, 1, 0, 0, 255, 1, 2, 18), "sat_255");
    apply(v(0, 0, 0, 1, 0, 0, 0, 255, 1, 2, 18), "sat_idle");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish required finish");
    $fatal(1);
  end

endmodule : tb_count_dir_decoder

`default_nettype wire
